muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Sequences the shared multiply/divide unit for the 5-stage pipeline and owns arbitration of the single regfile write port.
- When a mult/div instruction reaches Execute, the block starts the unit and holds the front end stalled until completion.
- It then writes the result (or an rstatus exception code) through the write port without colliding with normal writeback, and releases the pipeline.

Parameters:
MUL_LATENCY, 2, fixed cycles from unit_start to a valid mult result (>=1)
DIV_TIMEOUT, 64, BUSY cycles allowed for div before forced abort
RSTATUS, 30, register written on exception
MUL_EXC_CODE, 4, rstatus value on mult overflow
DIV_EXC_CODE, 5, rstatus value on divide-by-zero or timeout

Ports:
clock  input  1  master clock, all state updates on rising edge
reset  input  1  synchronous, active-low; reset==0 clears all state
issue_valid  input  1  DX holds a mult/div instruction
issue_is_div  input  1  1=div, 0=mult
issue_rd  input  5  destination register of the DX instruction
unit_start  output  1  one-cycle start pulse to mult/div unit
unit_ready  input  1  div result valid (ignored for mult)
unit_exception  input  1  overflow/div-by-zero flag, sampled with result
unit_result  input  32  unit result
stall  output  1  freeze PC/FD/DX, inject nop into XM
pipe_we  input  1  W-stage write enable
pipe_reg  input  5  W-stage destination
pipe_data  input  32  W-stage data
wr_en  output  1  regfile write enable
wr_reg  output  5  regfile write register
wr_data  output  32  regfile write data
busy  output  1  state != IDLE

Behaviour:
- Reset (reset==0 at edge): state=IDLE, counter=0, holding regs=0. While reset==0, all outputs are 0 combinationally, including wr_en (pipe write suppressed).
- States: IDLE, BUSY, WRITE, RELEASE.
- IDLE
  - issue_valid=0: stall=0, unit_start=0.
  - issue_valid=1: stall=1 and unit_start=1 combinationally, same cycle. Latch issue_rd and issue_is_div, counter<=0, next BUSY.
- BUSY: stall=1, unit_start=0, counter increments each cycle.
  - mult: in the cycle counter==MUL_LATENCY-1, capture unit_result and unit_exception; next WRITE.
  - div: in the first cycle unit_ready=1, capture the same; next WRITE.
  - div timeout: if counter==DIV_TIMEOUT-1 without unit_ready, capture exception=1; next WRITE. unit_ready in that same cycle wins over timeout.
- Captured target:
  - exception=0: reg=latched rd, data=unit_result.
  - exception=1: reg=RSTATUS, data=zero-extended MUL_EXC_CODE or DIV_EXC_CODE.
- WRITE: stall=1.
  - pipe_we=1: port passes pipe_*. Pipeline writeback has priority and is never delayed; stay in WRITE.
  - pipe_we=0: port drives captured reg/data, wr_en=1; next RELEASE.
  - Target reg==0 with no exception: wr_en=0, but state still advances to RELEASE on the first pipe_we=0 cycle.
- RELEASE: stall=0, issue_valid ignored for exactly this cycle (DX still holds the finished instruction and advances at this edge); next IDLE.
- Write port in IDLE, BUSY, RELEASE: wr_en/wr_reg/wr_data = pipe_we/pipe_reg/pipe_data.
- unit_start is asserted only in the IDLE→BUSY cycle; never re-asserted while busy.
- Minimum occupancy: mult with MUL_LATENCY=2 and no contention is IDLE(start) + 2 BUSY + WRITE + RELEASE. stall is high 4 cycles.
- Back-to-back mult/div: the second issue is accepted only in IDLE, at the earliest the cycle after RELEASE.
- Reset low mid-operation (any state): return to IDLE next edge; no pending write is performed.

Test Plan:
1. Reset held 0 for 3 cycles with issue_valid=1, pipe_we=1 -> all outputs 0, busy=0; after release with issue_valid=0, port passes pipe_* unchanged.
2. Mult, rd=5, MUL_LATENCY=2, unit_result=0x00000030, pipe_we=0 -> unit_start pulse in cycle 0; stall high cycles 0-3; wr_en=1, wr_reg=5, wr_data=0x30 in cycle 3; stall=0 in cycle 4; no second unit_start while issue_valid stays high through cycle 4.
3. Div, rd=7, unit_ready after 33 BUSY cycles, pipe_we=1 with reg=3, data=0xAA on the completion+1 and +2 cycles -> wr_reg=3, wr_data=0xAA on those two cycles; r7 written on the following cycle; stall released one cycle later.
4. Div with unit_exception=1 at ready -> wr_reg=30, wr_data=0x00000005; rd never written. Mult with overflow -> wr_reg=30, wr_data=0x00000004.
5. Div with no unit_ready -> timeout after 64 BUSY cycles; write r30=5, then RELEASE.
6. Mult rd=0, no exception -> no write asserted; stall drops after the WRITE and RELEASE sequence. Separately, reset=0 asserted mid-BUSY -> IDLE, no write, a fresh issue restarts cleanly.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared multiply/divide unit: starts the unit, stalls the front end,
// and merges the result into the single regfile write port behind normal writeback.
module muldiv_sequencer #(
  parameter int MUL_LATENCY  = 2,
  parameter int DIV_TIMEOUT  = 64,
  parameter int RSTATUS      = 30,
  parameter int MUL_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  output logic        unit_start,
  input  logic        unit_ready,
  input  logic        unit_exception,
  input  logic [31:0] unit_result,
  output logic        stall,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  output logic        wr_en,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data,
  output logic        busy
);

  localparam int CNT_MAX = (DIV_TIMEOUT > MUL_LATENCY) ? DIV_TIMEOUT : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY, WRITE, RELEASE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [4:0]         rd_reg, rd_next;
  logic               is_div_reg, is_div_next;
  logic [4:0]         tgt_reg_reg, tgt_reg_next;
  logic [31:0]        tgt_data_reg, tgt_data_next;
  logic               tgt_exc_reg, tgt_exc_next;
  logic               done;
  logic               exc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      rd_reg       <= '0;
      is_div_reg   <= 1'b0;
      tgt_reg_reg  <= '0;
      tgt_data_reg <= '0;
      tgt_exc_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      rd_reg       <= rd_next;
      is_div_reg   <= is_div_next;
      tgt_reg_reg  <= tgt_reg_next;
      tgt_data_reg <= tgt_data_next;
      tgt_exc_reg  <= tgt_exc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    rd_next       = rd_reg;
    is_div_next   = is_div_reg;
    tgt_reg_next  = tgt_reg_reg;
    tgt_data_next = tgt_data_reg;
    tgt_exc_next  = tgt_exc_reg;
    done          = 1'b0;
    exc           = 1'b0;
    stall         = 1'b0;
    unit_start    = 1'b0;
    wr_en         = pipe_we;
    wr_reg        = pipe_reg;
    wr_data       = pipe_data;
    busy          = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (issue_valid) begin
          stall       = 1'b1;
          unit_start  = 1'b1;
          rd_next     = issue_rd;
          is_div_next = issue_is_div;
          count_next  = '0;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        stall      = 1'b1;
        count_next = count_reg + CNT_W'(1);
        // A ready in the timeout cycle is a real result, so it is tested first.
        if (is_div_reg) begin
          if (unit_ready) begin
            done = 1'b1;
            exc  = unit_exception;
          end else if (count_reg == CNT_W'(DIV_TIMEOUT - 1)) begin
            done = 1'b1;
            exc  = 1'b1;
          end
        end else if (count_reg == CNT_W'(MUL_LATENCY - 1)) begin
          done = 1'b1;
          exc  = unit_exception;
        end
        if (done) begin
          state_next   = WRITE;
          tgt_exc_next = exc;
          if (exc) begin
            tgt_reg_next  = 5'(RSTATUS);
            tgt_data_next = is_div_reg ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
          end else begin
            tgt_reg_next  = rd_reg;
            tgt_data_next = unit_result;
          end
        end
      end
      WRITE: begin
        stall = 1'b1;
        // Normal writeback owns the port whenever it wants it; we wait.
        if (!pipe_we) begin
          wr_en      = tgt_exc_reg || (tgt_reg_reg != 5'd0);
          wr_reg     = tgt_reg_reg;
          wr_data    = tgt_data_reg;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (!reset) begin
      stall      = 1'b0;
      unit_start = 1'b0;
      wr_en      = 1'b0;
      wr_reg     = '0;
      wr_data    = '0;
      busy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: drives after each rising edge, checks at the falling edge.
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_is_div;
  logic [4:0]  issue_rd;
  logic        unit_start;
  logic        unit_ready;
  logic        unit_exception;
  logic [31:0] unit_result;
  logic        stall;
  logic        pipe_we;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_is_div   (issue_is_div),
    .issue_rd       (issue_rd),
    .unit_start     (unit_start),
    .unit_ready     (unit_ready),
    .unit_exception (unit_exception),
    .unit_result    (unit_result),
    .stall          (stall),
    .pipe_we        (pipe_we),
    .pipe_reg       (pipe_reg),
    .pipe_data      (pipe_data),
    .wr_en          (wr_en),
    .wr_reg         (wr_reg),
    .wr_data        (wr_data),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Waits for the falling edge of the current cycle and checks the outputs.
  task automatic exp_out(input string tag, input logic st, input logic us, input logic bz,
                         input logic we, input logic [4:0] r, input logic [31:0] d);
    @(negedge clock);
    chk({tag, ".stall"}, 32'(stall), 32'(st));
    chk({tag, ".unit_start"}, 32'(unit_start), 32'(us));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(we));
    if (we) begin
      chk({tag, ".wr_reg"}, 32'(wr_reg), 32'(r));
      chk({tag, ".wr_data"}, wr_data, d);
    end
  endtask

  task automatic issue(input logic is_div, input logic [4:0] rd);
    issue_valid  = 1'b1;
    issue_is_div = is_div;
    issue_rd     = rd;
  endtask

  initial begin
    reset = 1'b0; issue_valid = 1'b1; issue_is_div = 1'b0; issue_rd = 5'd4;
    unit_ready = 1'b0; unit_exception = 1'b0; unit_result = '0;
    pipe_we = 1'b1; pipe_reg = 5'd9; pipe_data = 32'h55;

    // Reset held low: everything forced to zero, including the pipe write.
    for (int i = 0; i < 3; i++) begin
      exp_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      chk("rst.wr_reg", 32'(wr_reg), 32'd0);
      chk("rst.wr_data", wr_data, 32'd0);
      cyc();
    end
    reset = 1'b1; issue_valid = 1'b0;
    exp_out("post_rst_pass", 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h55);
    cyc();
    $display("txn reset: done");
    pipe_we = 1'b0; pipe_reg = '0; pipe_data = '0;

    // Mult rd=5, no contention; issue_valid stays high through RELEASE.
    issue(1'b0, 5'd5); unit_result = 32'h30;
    exp_out("mul_c0", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    exp_out("mul_c1", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    exp_out("mul_c2", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    unit_result = 32'hFFFF_0000;
    exp_out("mul_c3", 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h30); cyc();
    exp_out("mul_c4", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    issue_valid = 1'b0;
    exp_out("mul_c5", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    $display("txn mult rd=5 result=0x30");

    // Div rd=7, ready after 33 BUSY cycles, writeback contention for two cycles.
    issue(1'b1, 5'd7);
    exp_out("div_start", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    issue_valid = 1'b0;
    for (int i = 0; i < 33; i++) begin
      exp_out("div_busy", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    end
    unit_ready = 1'b1; unit_result = 32'h1234_5678;
    exp_out("div_ready", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    unit_ready = 1'b0; unit_result = 32'hDEAD_BEEF;
    pipe_we = 1'b1; pipe_reg = 5'd3; pipe_data = 32'hAA;
    exp_out("div_pipe1", 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'hAA); cyc();
    exp_out("div_pipe2", 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'hAA); cyc();
    pipe_we = 1'b0; pipe_reg = '0; pipe_data = '0;
    exp_out("div_wr", 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h1234_5678); cyc();
    exp_out("div_rel", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    exp_out("div_idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    $display("txn div rd=7 result=0x12345678 with 2 contention cycles");

    // Div by zero: exception at ready goes to rstatus.
    issue(1'b1, 5'd8);
    exp_out("dexc_start", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    issue_valid = 1'b0; unit_ready = 1'b1; unit_exception = 1'b1; unit_result = 32'h99;
    exp_out("dexc_busy", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    unit_ready = 1'b0; unit_exception = 1'b0;
    exp_out("dexc_wr", 1'b1, 1'b0, 1'b1, 1'b1, 5'd30, 32'h5); cyc();
    exp_out("dexc_rel", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    $display("txn div exception -> r30=5");

    // Mult overflow flagged only in the capture cycle.
    issue(1'b0, 5'd6);
    exp_out("mexc_start", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    issue_valid = 1'b0;
    exp_out("mexc_b0", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    unit_exception = 1'b1;
    exp_out("mexc_b1", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    unit_exception = 1'b0;
    exp_out("mexc_wr", 1'b1, 1'b0, 1'b1, 1'b1, 5'd30, 32'h4); cyc();
    exp_out("mexc_rel", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    $display("txn mult overflow -> r30=4");

    // Div that never completes: timeout after 64 BUSY cycles.
    issue(1'b1, 5'd11);
    exp_out("tmo_start", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    issue_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      exp_out("tmo_busy", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    end
    exp_out("tmo_wr", 1'b1, 1'b0, 1'b1, 1'b1, 5'd30, 32'h5); cyc();
    exp_out("tmo_rel", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    exp_out("tmo_idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    $display("txn div timeout -> r30=5");

    // Mult into r0: no write, but the sequence still completes.
    issue(1'b0, 5'd0); unit_result = 32'h42;
    exp_out("r0_start", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    issue_valid = 1'b0;
    exp_out("r0_b0", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    exp_out("r0_b1", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    exp_out("r0_wr", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    exp_out("r0_rel", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    exp_out("r0_idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    $display("txn mult rd=0 -> no write");

    // Reset asserted mid-BUSY, then a fresh mult.
    issue(1'b1, 5'd12);
    exp_out("mid_start", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    issue_valid = 1'b0;
    exp_out("mid_busy", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    reset = 1'b0; pipe_we = 1'b1; pipe_reg = 5'd4; pipe_data = 32'h1;
    exp_out("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("mid_rst.wr_reg", 32'(wr_reg), 32'd0);
    chk("mid_rst.wr_data", wr_data, 32'd0);
    cyc();
    reset = 1'b1; pipe_we = 1'b0; pipe_reg = '0; pipe_data = '0;
    unit_ready = 1'b1; unit_result = 32'h5555;
    exp_out("mid_post", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    unit_ready = 1'b0;
    exp_out("mid_idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    issue(1'b0, 5'd9); unit_result = 32'h77;
    exp_out("fresh_start", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); cyc();
    issue_valid = 1'b0;
    exp_out("fresh_b0", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    exp_out("fresh_b1", 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    exp_out("fresh_wr", 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h77); cyc();
    exp_out("fresh_rel", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0); cyc();
    $display("txn reset mid-busy then mult rd=9 result=0x77");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
